lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store memory-port controller for the RV64I MEM stage. Accepts one load or store request at a time from EX, checks alignment, drives an 8-byte-aligned data-memory bus with byte strobes and a bus-timeout guard, and returns the raw 64-bit memory word, width code and byte offset. That response is exactly what the downstream load-extract stage consumes: it shifts the word by the byte offset and sign- or zero-extends it.

## Interface
- DATA_WIDTH, 64, data path width; only 64 is supported.
- TIMEOUT_CYCLES, 255, maximum number of cycles `mem_valid_o` stays asserted before the access is aborted; legal range 1..255.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when `req_valid_i && req_ready_o`.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  64  byte address.
- req_wid_i  in  3  width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_wdata_i  in  64  store data, right-justified.
- mem_valid_o  out  1  bus request.
- mem_ready_i  in  1  bus completes in the cycle where `mem_valid_o && mem_ready_i`.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  64  `{req_addr[63:3], 3'b000}`.
- mem_wdata_o  out  64  store data shifted into its lane.
- mem_wstrb_o  out  8  byte strobes; 0 for loads.
- mem_rdata_i  in  64  read data; sampled in the completion cycle.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_data_o  out  64  raw captured word; 0 for stores and faults.
- rsp_wid_o  out  3  latched width code.
- rsp_byteena_o  out  3  latched `addr[2:0]`.
- rsp_we_o  out  1  latched direction.
- rsp_fault_o  out  1  access failed.
- rsp_cause_o  out  2  00 none, 01 misaligned/illegal width, 10 bus timeout.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready_o = 1`, except while `rst` is high, when it is 0.
  - On accept, latch we, addr, wid, wdata and offset `addr[2:0]`.
  - Fault check:
    - H/HU require `addr[0]=0`.
    - W/WU require `addr[1:0]=0`.
    - D requires `addr[2:0]=0`.
    - wid 111 is illegal.
    - A store with `wid[2]=1` is illegal.
  - On fault: go to RESP with cause 01. No bus access is made.
  - Otherwise: go to BUS and clear the timeout counter.
- **BUS**
  - `mem_valid_o = 1`; `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_wstrb_o` come from latched values and are stable until completion.
  - Strobes:
    - B: `8'h01 << off`
    - H: `8'h03 << off`
    - W: `8'h0F << off`
    - D: `8'hFF`
  - Store lane: `mem_wdata_o = wdata << (off*8)`.
  - On `mem_ready_i`:
    - For a load, capture `mem_rdata_i`.
    - Go to RESP with cause 00.
  - Otherwise the counter increments each cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 and `mem_ready_i` is still low, go to RESP with cause 10.
  - If `mem_ready_i` arrives in that final cycle, ready wins.
- **RESP**
  - `rsp_valid_o = 1` for exactly one cycle, then return to IDLE.
  - The `rsp_*` fields are valid only while `rsp_valid_o` is high. Between pulses they hold their last value.
  - The downstream stage has no backpressure.
- The controller never holds more than one request outstanding.
- Reset mid-access: `mem_valid_o` drops immediately (asynchronous) and the access is abandoned. No response is produced.

## Timing
- Reset values:
  - state IDLE; counter 0.
  - `mem_valid_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o` all 0.
  - `rsp_valid_o`, `rsp_data_o`, `rsp_wid_o`, `rsp_byteena_o`, `rsp_we_o`, `rsp_fault_o`, `rsp_cause_o` all 0.
  - `req_ready_o` 0 while `rst` is high.
- Request accepted in cycle 0:
  - `mem_valid_o` goes high in cycle 1.
  - If `mem_ready_i` is high in cycle 1+k, `rsp_valid_o` is high in cycle 2+k.
- A faulting request accepted in cycle 0 gives `rsp_valid_o` in cycle 1.
- `req_ready_o` returns to 1 in the cycle after `rsp_valid_o`. Minimum issue interval is 3 cycles.
- A timeout response arrives in cycle TIMEOUT_CYCLES+1, after `mem_valid_o` has been high for exactly TIMEOUT_CYCLES cycles.
- `mem_*` outputs and `rsp_*` outputs are registered.
- `req_ready_o` is decoded directly from the FSM state.

## Test plan
- LW at `0x1004`, `mem_rdata_i=0x8765_4321_0000_0000`, ready in the first BUS cycle:
  - `mem_addr_o=0x1000`, `mem_wstrb_o=0`.
  - `rsp_valid_o` 2 cycles after accept with `rsp_data_o=0x8765_4321_0000_0000`, `rsp_byteena_o=4`, `rsp_wid_o=010`, fault 0.
- SH of `0xBEEF` at `0x2006`, ready after 3 cycles:
  - `mem_wstrb_o=0xC0`, `mem_wdata_o=0xBEEF_0000_0000_0000`, `mem_we_o=1`, all held stable for 4 cycles.
  - Response `rsp_we_o=1`, `rsp_data_o=0`.
- LD at `0x3004`:
  - `mem_valid_o` never asserts.
  - `rsp_valid_o` 1 cycle after accept with `rsp_fault_o=1`, `rsp_cause_o=01`.
  - Also cover a store with wid 100, which gives the same response.
- Timeout with TIMEOUT_CYCLES=4 and `mem_ready_i` held low:
  - `mem_valid_o` high for exactly 4 cycles, then a response with cause 10.
  - Repeat with ready in the 4th cycle: response with cause 00.
- Back-to-back requests with `req_valid_i` held high:
  - Second accept occurs the cycle after the first `rsp_valid_o`.
  - No overlap of `mem_valid_o` between the two accesses.
- Assert `rst` in the second BUS cycle:
  - `mem_valid_o` goes to 0 at once and no `rsp_valid_o` pulse follows.
  - After release, a fresh LB completes normally.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Request, data-memory bus and response bundle for the RV64I MEM-stage port.
// The LSU port takes the slave view; EX, memory and load-extract take master.
interface lsu_mem_port_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [2:0]  req_wid_i;
    logic [63:0] req_wdata_i;

    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic [63:0] mem_rdata_i;

    logic        rsp_valid_o;
    logic [63:0] rsp_data_o;
    logic [2:0]  rsp_wid_o;
    logic [2:0]  rsp_byteena_o;
    logic        rsp_we_o;
    logic        rsp_fault_o;
    logic [1:0]  rsp_cause_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wid_i, req_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  req_ready_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  rsp_valid_o, rsp_data_o, rsp_wid_o, rsp_byteena_o,
        input  rsp_we_o, rsp_fault_o, rsp_cause_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wid_i, req_wdata_i,
        input  mem_ready_i, mem_rdata_i,
        output req_ready_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output rsp_valid_o, rsp_data_o, rsp_wid_o, rsp_byteena_o,
        output rsp_we_o, rsp_fault_o, rsp_cause_o
    );
endinterface

// File: rtl/lsu_mem_port.sv
// RV64I MEM-stage load/store port: alignment check, 8-byte-aligned bus access
// with byte strobes and timeout, raw word response for the load-extract stage.
module lsu_mem_port #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [2:0]              wid_q, wid_d;
    logic [2:0]              off_q, off_d;

    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_we_q, mem_we_d;
    logic [63:0]             mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]              mem_wstrb_q, mem_wstrb_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [2:0]              rsp_wid_q, rsp_wid_d;
    logic [2:0]              rsp_byteena_q, rsp_byteena_d;
    logic                    rsp_we_q, rsp_we_d;
    logic                    rsp_fault_q, rsp_fault_d;
    logic [1:0]              rsp_cause_q, rsp_cause_d;

    logic                    accept;
    logic                    misalign;
    logic [7:0]              strb_base;

    assign bus.req_ready_o = (state_q == IDLE) && !rst;
    assign accept = bus.req_valid_i && bus.req_ready_o;

    // Width decode: bit 2 only selects zero-extension, so it never affects lanes.
    always_comb begin
        misalign  = 1'b0;
        strb_base = 8'h00;
        unique case (1'b1)
            bus.req_wid_i == 3'b111: misalign = 1'b1;
            bus.req_wid_i[1:0] == 2'b00: strb_base = 8'h01;
            bus.req_wid_i[1:0] == 2'b01: begin
                misalign  = bus.req_addr_i[0];
                strb_base = 8'h03;
            end
            bus.req_wid_i[1:0] == 2'b10: begin
                misalign  = |bus.req_addr_i[1:0];
                strb_base = 8'h0F;
            end
            default: begin
                misalign  = |bus.req_addr_i[2:0];
                strb_base = 8'hFF;
            end
        endcase
        if (bus.req_we_i && bus.req_wid_i[2]) misalign = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wid_d         = wid_q;
        off_d         = off_q;
        mem_valid_d   = mem_valid_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_wid_d     = rsp_wid_q;
        rsp_byteena_d = rsp_byteena_q;
        rsp_we_d      = rsp_we_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_cause_d   = rsp_cause_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wid_d = bus.req_wid_i;
                    off_d = bus.req_addr_i[2:0];
                    if (misalign) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = '0;
                        rsp_wid_d     = bus.req_wid_i;
                        rsp_byteena_d = bus.req_addr_i[2:0];
                        rsp_we_d      = bus.req_we_i;
                        rsp_fault_d   = 1'b1;
                        rsp_cause_d   = 2'b01;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        mem_valid_d = 1'b1;
                        mem_we_d    = bus.req_we_i;
                        mem_addr_d  = {bus.req_addr_i[63:3], 3'b000};
                        mem_wdata_d = bus.req_we_i ?
                            bus.req_wdata_i << {bus.req_addr_i[2:0], 3'b000} : '0;
                        mem_wstrb_d = bus.req_we_i ?
                            strb_base << bus.req_addr_i[2:0] : 8'h00;
                    end
                end
            end
            BUS: begin
                if (bus.mem_ready_i || cnt_q == CntLast) begin
                    state_d       = RESP;
                    mem_valid_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_wid_d     = wid_q;
                    rsp_byteena_d = off_q;
                    rsp_we_d      = mem_we_q;
                    // Ready in the final counted cycle still completes.
                    if (bus.mem_ready_i) begin
                        rsp_data_d  = mem_we_q ? '0 : bus.mem_rdata_i;
                        rsp_fault_d = 1'b0;
                        rsp_cause_d = 2'b00;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_fault_d = 1'b1;
                        rsp_cause_d = 2'b10;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wid_q         <= '0;
            off_q         <= '0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_wid_q     <= '0;
            rsp_byteena_q <= '0;
            rsp_we_q      <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_cause_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wid_q         <= wid_d;
            off_q         <= off_d;
            mem_valid_q   <= mem_valid_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_wid_q     <= rsp_wid_d;
            rsp_byteena_q <= rsp_byteena_d;
            rsp_we_q      <= rsp_we_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_cause_q   <= rsp_cause_d;
        end
    end

    assign bus.mem_valid_o   = mem_valid_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.mem_wstrb_o   = mem_wstrb_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_data_o    = rsp_data_q;
    assign bus.rsp_wid_o     = rsp_wid_q;
    assign bus.rsp_byteena_o = rsp_byteena_q;
    assign bus.rsp_we_o      = rsp_we_q;
    assign bus.rsp_fault_o   = rsp_fault_q;
    assign bus.rsp_cause_o   = rsp_cause_q;
endmodule
